// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
//   Four requesters share one write port. Ownership is granted round-robin
//   and held until the owner signals its last beat, drops req, or has held
//   the port for HOLD_MAX cycles. On release the next owner is picked in the
//   same cycle, so there is no gap between owners. The releasing requester
//   is masked out of that pick, so it must wait through one idle cycle
//   before it can own the port again.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   req[3:0], last[3:0]   per-requester write request / final-beat marker
//   waddr_in, wdata_in    per-requester address/data, slice i at [i*W +: W]
//   gnt[3:0], gnt_idx     one-hot owner and its binary index (0 when idle)
//   busy                  a requester owns the port
//   wr_en/wr_addr/wr_data shared write port, muxed from the owner's slice
module wr_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          req,
    input  logic [3:0]          last,
    input  logic [4*ADDR_W-1:0] waddr_in,
    input  logic [4*WIDTH-1:0]  wdata_in,
    output logic [3:0]          gnt,
    output logic [1:0]          gnt_idx,
    output logic                busy,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WIDTH-1:0]    wr_data
);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t      state, state_nx;
    logic [1:0]  ptr, ptr_nx;
    logic [1:0]  idx_nx;
    logic        busy_nx;
    logic [3:0]  gnt_nx;
    logic [7:0]  hold_cnt, hold_nx;

    logic [3:0][ADDR_W-1:0] addr_v;
    logic [3:0][WIDTH-1:0]  data_v;

    for (genvar i = 0; i < 4; i++) begin : g_slice
        assign addr_v[i] = waddr_in[i*ADDR_W +: ADDR_W];
        assign data_v[i] = wdata_in[i*WIDTH +: WIDTH];
    end

    // Round-robin search starting at p; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
        logic       found;
        logic [1:0] cand;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = p + 2'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return {found, win};
    endfunction

    logic       rel;
    logic [1:0] rel_ptr;
    logic [2:0] pick_idle, pick_rel;

    // Release: normal end, abandon, or hold limit reached.
    assign rel       = (state == OWNED) &&
                       (!req[gnt_idx] || last[gnt_idx] || hold_cnt == HOLD_LIM);
    assign rel_ptr   = gnt_idx + 2'd1;
    assign pick_idle = rr_pick(ptr, req);
    // Owner is masked so it cannot win the pick made on its own release.
    assign pick_rel  = rr_pick(rel_ptr, req & ~(4'b0001 << gnt_idx));

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        idx_nx   = gnt_idx;
        busy_nx  = busy;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_nx = OWNED;
                    idx_nx   = pick_idle[1:0];
                    busy_nx  = 1'b1;
                    hold_nx  = 8'd1;
                end
            end
            OWNED: begin
                if (rel) begin
                    ptr_nx = rel_ptr;
                    if (pick_rel[2]) begin
                        idx_nx  = pick_rel[1:0];
                        hold_nx = 8'd1;
                    end else begin
                        state_nx = IDLE;
                        idx_nx   = 2'd0;
                        busy_nx  = 1'b0;
                        hold_nx  = 8'd0;
                    end
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = 2'd0;
                busy_nx  = 1'b0;
                hold_nx  = 8'd0;
            end
        endcase
        gnt_nx = busy_nx ? (4'b0001 << idx_nx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            gnt_idx  <= 2'd0;
            busy     <= 1'b0;
            gnt      <= 4'b0000;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            gnt_idx  <= idx_nx;
            busy     <= busy_nx;
            gnt      <= gnt_nx;
            hold_cnt <= hold_nx;
        end
    end

    // busy is a reset flop, so the shared port goes quiet as soon as reset asserts.
    assign wr_en   = busy & req[gnt_idx];
    assign wr_addr = busy ? addr_v[gnt_idx] : '0;
    assign wr_data = busy ? data_v[gnt_idx] : '0;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Directed bench for wr_port_arbiter: reset, single request, round-robin,
// burst, forced release, sole-requester re-grant, reset mid-burst.
module tb_wr_port_arbiter;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [3:0]          req, last;
    logic [4*ADDR_W-1:0] waddr_in;
    logic [4*WIDTH-1:0]  wdata_in;
    logic [3:0]          gnt;
    logic [1:0]          gnt_idx;
    logic                busy, wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WIDTH-1:0]    wr_data;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    wr_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .HOLD_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .last(last),
        .waddr_in(waddr_in), .wdata_in(wdata_in),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req     = 4'b0000;
        last    = 4'b0000;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    initial begin
        waddr_in = {4'd8, 4'd7, 4'd6, 4'd5};
        wdata_in = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

        // Reset state, with requests present: the port must stay quiet.
        reset_n = 1'b0;
        req     = 4'b1111;
        last    = 4'b0000;
        tick;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_idx", gnt_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_addr", wr_addr, 4'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_ptr", dut.ptr, 2'd0);

        // Single request from requester 2.
        do_reset;
        req  = 4'b0100;
        last = 4'b0100;
        tick;
        chk("single_gnt", gnt, 4'b0100);
        chk("single_idx", gnt_idx, 2'd2);
        chk("single_wr_en", wr_en, 1'b1);
        chk("single_addr", wr_addr, 4'd7);
        chk("single_data", wr_data, 32'hCAFE_0002);
        tick;
        req  = 4'b0000;
        last = 4'b0000;
        chk("single_busy_after", busy, 1'b0);
        chk("single_gnt_after", gnt, 4'b0000);
        chk("single_ptr", dut.ptr, 2'd3);

        // Round-robin with all requesters, one beat each, back to back.
        do_reset;
        req  = 4'b1111;
        last = 4'b1111;
        tick;
        chk("rr_gnt0", gnt, 4'b0001);
        chk("rr_idx0", gnt_idx, 2'd0);
        chk("rr_wr0", wr_en, 1'b1);
        tick;
        chk("rr_gnt1", gnt, 4'b0010);
        chk("rr_idx1", gnt_idx, 2'd1);
        tick;
        chk("rr_gnt2", gnt, 4'b0100);
        chk("rr_busy2", busy, 1'b1);
        tick;
        chk("rr_gnt3", gnt, 4'b1000);
        chk("rr_idx3", gnt_idx, 2'd3);
        chk("rr_data3", wr_data, 32'hCAFE_0003);
        tick;
        chk("rr_gnt4", gnt, 4'b0001);

        // Four-beat burst from requester 1, then requester 0 with no gap.
        do_reset;
        req  = 4'b0010;
        last = 4'b0000;
        tick;
        pulses = 0;
        for (int c = 1; c <= 4; c++) begin
            req  = 4'b0011;
            last = (c == 4) ? 4'b0010 : 4'b0000;
            chk($sformatf("burst_gnt%0d", c), gnt, 4'b0010);
            if (wr_en) pulses++;
            tick;
        end
        chk("burst_pulses", pulses, 4);
        chk("burst_next_gnt", gnt, 4'b0001);
        chk("burst_next_addr", wr_addr, 4'd5);

        // Forced release after 8 cycles for requester 3.
        do_reset;
        req  = 4'b1000;
        last = 4'b0000;
        tick;
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            req = 4'b1001;
            chk($sformatf("force_gnt%0d", c), gnt, 4'b1000);
            if (wr_en) pulses++;
            tick;
        end
        chk("force_pulses", pulses, 8);
        chk("force_next_gnt", gnt, 4'b0001);
        chk("force_ptr", dut.ptr, 2'd0);

        // Sole requester must sit out one idle cycle between grants.
        do_reset;
        req  = 4'b0001;
        last = 4'b0001;
        tick;
        chk("sole_gnt_a", gnt, 4'b0001);
        tick;
        chk("sole_gnt_gap", gnt, 4'b0000);
        chk("sole_wr_gap", wr_en, 1'b0);
        tick;
        chk("sole_gnt_b", gnt, 4'b0001);

        // Reset asserted in the middle of a requester-2 burst.
        do_reset;
        req  = 4'b0100;
        last = 4'b0000;
        tick;
        tick;
        chk("mid_pre_gnt", gnt, 4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_gnt", gnt, 4'b0000);
        chk("mid_wr_en", wr_en, 1'b0);
        chk("mid_addr", wr_addr, 4'd0);
        req = 4'b0110;
        tick;
        reset_n = 1'b1;
        tick;
        chk("mid_after_gnt", gnt, 4'b0010);
        chk("mid_after_idx", gnt_idx, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wr_port_arbiter.md
WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: write-data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: write-address width in bits.
REQ-003 SHALL have parameter HOLD_MAX, default 8, legal range 1..255: maximum number of cycles one requester may own the port.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset; asynchronous, active-low.
REQ-006 SHALL have port req, input, 4: req[i] high means requester i wants a write beat.
REQ-007 SHALL have port last, input, 4: last[i] high marks requester i's final beat; ignored unless req[i] is high.
REQ-008 SHALL have port waddr_in, input, 4*ADDR_W: requester i's address in bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata_in, input, 4*WIDTH: requester i's data in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port gnt, output, 4: one-hot current owner, or all zero.
REQ-011 SHALL have port gnt_idx, output, 2: binary index of the owner; 0 when there is no owner.
REQ-012 SHALL have port busy, output, 1: high while any requester owns the port.
REQ-013 SHALL have port wr_en, output, 1: shared write-port enable.
REQ-014 SHALL have port wr_addr, output, ADDR_W: shared write-port address.
REQ-015 SHALL have port wr_data, output, WIDTH: shared write-port data.

Function
REQ-016 SHALL use a two-state FSM.
- IDLE: no owner.
- OWNED: one requester holds the port.
REQ-017 SHALL keep gnt, gnt_idx, busy, state, a 2-bit round-robin pointer ptr and a hold counter in registers.
REQ-018 SHALL make gnt equal the 2-to-4 one-hot decode of gnt_idx, gated by busy.
REQ-019 SHALL, in IDLE with any req bit high, choose a winner and register it, then enter OWNED.
- Winner: the first requester with req high, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
- Latency: gnt is high one cycle after req is sampled.
REQ-020 SHALL, in IDLE with req == 0, remain in IDLE and leave ptr unchanged.
REQ-021 SHALL drive wr_en = busy & req[gnt_idx], combinationally.
REQ-022 SHALL drive wr_addr and wr_data from the owner's slice of waddr_in/wdata_in, and drive 0 on both when busy is low.
REQ-023 SHALL count one hold cycle per OWNED cycle, starting at 1 in the first OWNED cycle.
REQ-024 SHALL raise a release condition in OWNED when any of the following holds:
- req[owner] & last[owner] (normal end);
- req[owner] is low (abandon);
- hold count == HOLD_MAX (forced).
REQ-025 SHALL, on release, set ptr to owner+1 mod 4.
REQ-026 SHALL, on release, re-arbitrate in the same cycle using the updated ptr and the current req with the owner's bit masked.
- If there is a winner, grant it on the next edge (back-to-back, no idle cycle) and restart the hold count at 1.
- If there is none, return to IDLE.
REQ-027 SHALL never grant the releasing requester in the cycle immediately after its release, even when it is the sole requester.
- It regains the port only after one IDLE cycle.
REQ-028 SHALL count the beat on which a forced release occurs as a valid write (wr_en per REQ-021).
REQ-029 SHALL ignore req changes of non-owners while OWNED.
REQ-030 SHALL never assert more than one gnt bit, and SHALL keep gnt stable between releases.
REQ-031 SHALL wrap ptr from 3 to 0.

Reset
REQ-032 SHALL, while reset_n is low, immediately force all of the following, independent of clk:
- state=IDLE, gnt=0, gnt_idx=0, busy=0, ptr=0, hold count=0;
- wr_en=0, wr_addr=0, wr_data=0.
REQ-033 SHALL, on reset assertion mid-ownership, abandon the ownership with no further write beat.
REQ-034 SHALL begin arbitration on the first rising edge after reset_n rises, with priority order 0,1,2,3.

Verification
REQ-035 SHALL cover single request: after reset, req=0100, last=0100 for one cycle.
- Next cycle: gnt=0100, gnt_idx=2, wr_en=1, wr_addr/wr_data equal slice 2.
- Following cycle: busy=0.
- ptr=3.
REQ-036 SHALL cover round-robin fairness: req=1111 held, last=1111.
- Grants are 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- No idle cycle between grants.
REQ-037 SHALL cover multi-beat burst: requester 1 holds req with last low for 3 cycles, then high while req=0011.
- gnt=0010 for 4 cycles with 4 wr_en pulses.
- Then gnt=0001 immediately.
REQ-038 SHALL cover forced release: HOLD_MAX=8, requester 3 holds req with last=0 while req[0] is high.
- gnt=1000 for exactly 8 cycles with 8 wr_en pulses.
- Then gnt=0001.
REQ-039 SHALL cover sole-requester re-grant: req=0001 held, last=0001.
- gnt alternates 0001, 0000, 0001.
REQ-040 SHALL cover reset mid-operation: reset_n low during a requester-2 burst.
- Same cycle: gnt=0, wr_en=0.
- After release of reset with req=0110: grant goes to requester 1 (ptr=0).
